// File: rtl/led_7seg_mux_counter.sv
// Cascaded BCD up/down counter with a time-multiplexed 7-segment drive.
// One digit is lit at a time; seg/dig are registered one cycle behind.
module led_7seg_mux_counter #(
  parameter int NUM_DIGITS     = 4,
  parameter int CNT_WIDTH      = 24,
  parameter int SCAN_DIV       = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clr,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_WIDTH-1:0]    presc;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] nxtVal;
  logic                    carry;
  logic [SCAN_DIV-1:0]     scan;
  logic [IW-1:0]           idx;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lz;
  logic [3:0]              curDig;
  logic                    curDp;
  logic                    curBlank;
  logic [NUM_DIGITS-1:0]   selOh;
  logic [7:0]              segCode;
  logic [7:0]              segRaw;

  assign tick = en & (&presc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (en) begin
      presc <= presc + 1'b1;
    end
  end

  // Ripple the step through the digits; carry survives only past terminal digits
  always_comb begin
    nxtVal = value;
    carry  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (up) begin
          if (value[4*i +: 4] == 4'd9) begin
            nxtVal[4*i +: 4] = 4'd0;
          end else begin
            nxtVal[4*i +: 4] = value[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (value[4*i +: 4] == 4'd0) begin
            nxtVal[4*i +: 4] = 4'd9;
          end else begin
            nxtVal[4*i +: 4] = value[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      value <= '0;
      wrap  <= 1'b0;
    end else if (tick) begin
      value <= nxtVal;
      wrap  <= carry;
    end else begin
      wrap  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan <= '0;
      idx  <= '0;
    end else begin
      scan <= scan + 1'b1;
      if (&scan) begin
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_comb begin
    lz    = 1'b1;
    blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz = lz & (value[4*k +: 4] == 4'd0);
      if (BLANK_LZ != 0 && k > 0) begin
        blank[k] = lz;
      end
    end
  end

  always_comb begin
    curDig   = 4'd0;
    curDp    = 1'b0;
    curBlank = 1'b0;
    selOh    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        curDig   = value[4*i +: 4];
        curDp    = dp[i];
        curBlank = blank[i];
        selOh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    segCode = 8'h00;
    case (curDig)
      4'd0:    segCode = 8'hFC;
      4'd1:    segCode = 8'h60;
      4'd2:    segCode = 8'hDA;
      4'd3:    segCode = 8'hF2;
      4'd4:    segCode = 8'h66;
      4'd5:    segCode = 8'hB6;
      4'd6:    segCode = 8'hBE;
      4'd7:    segCode = 8'hE0;
      4'd8:    segCode = 8'hFE;
      4'd9:    segCode = 8'hF6;
      default: segCode = 8'h00;
    endcase
    segRaw = {curBlank ? 7'd0 : segCode[7:1], curDp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      dig <= DIG_OFF;
    end else begin
      seg <= (SEG_ACTIVE_LOW != 0) ? ~segRaw : segRaw;
      dig <= (DIG_ACTIVE_LOW != 0) ? ~selOh : selOh;
    end
  end

endmodule
